// File: rtl/rtc_pkg.sv
// Shared types and helpers for the time-of-day counter.
// State encoding, width helper and default moduli.
package rtc_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } rtc_state_e;

  localparam int DEF_MOD_SEC = 60;
  localparam int DEF_MOD_MIN = 60;
  localparam int DEF_MOD_HR  = 24;

  function automatic int rtc_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/rtc_tick_gen.sv
// Prescaler producing a one-cycle tick enable every DIV running cycles.
// Ports: clk_i, rst_ni, run_i (count), clr_i (restart at 0), tick_en_o.
module rtc_tick_gen
  import rtc_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic clr_i,
  output logic tick_en_o
);

  localparam int CW = rtc_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap      = (cnt_q == LAST);
  assign tick_en_o = run_i & wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rtc_hms_counter.sv
// Hours/minutes/seconds counter with run/stop, checked load and alarm.
// Ports: hclk/reset_n, run_en, set_* handshake, alarm_*, time and pulses.
module rtc_hms_counter
  import rtc_pkg::*;
#(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 1,
  parameter int MOD_SEC = DEF_MOD_SEC,
  parameter int MOD_MIN = DEF_MOD_MIN,
  parameter int MOD_HR  = DEF_MOD_HR
) (
  input  logic                       hclk,
  input  logic                       reset_n,
  input  logic                       run_en,
  input  logic                       set_valid,
  output logic                       set_ready,
  input  logic [rtc_w(MOD_SEC)-1:0]  set_sec,
  input  logic [rtc_w(MOD_MIN)-1:0]  set_min,
  input  logic [rtc_w(MOD_HR)-1:0]   set_hr,
  output logic                       set_err,
  input  logic                       alarm_en,
  input  logic [rtc_w(MOD_SEC)-1:0]  alarm_sec,
  input  logic [rtc_w(MOD_MIN)-1:0]  alarm_min,
  input  logic [rtc_w(MOD_HR)-1:0]   alarm_hr,
  output logic [rtc_w(MOD_SEC)-1:0]  seconds,
  output logic [rtc_w(MOD_MIN)-1:0]  minutes,
  output logic [rtc_w(MOD_HR)-1:0]   hours,
  output logic                       tick,
  output logic                       min_wrap,
  output logic                       day_wrap,
  output logic                       alarm_hit
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int SW  = rtc_w(MOD_SEC);
  localparam int MW  = rtc_w(MOD_MIN);
  localparam int HW  = rtc_w(MOD_HR);
  localparam logic [SW-1:0] SMAX = SW'(MOD_SEC - 1);
  localparam logic [MW-1:0] MMAX = MW'(MOD_MIN - 1);
  localparam logic [HW-1:0] HMAX = HW'(MOD_HR - 1);

  rtc_state_e    state_q, state_d;
  logic [SW-1:0] sec_q, sec_d;
  logic [MW-1:0] min_q, min_d;
  logic [HW-1:0] hr_q, hr_d;
  logic          ready_q, err_q;
  logic          tick_q, mwrap_q, dwrap_q, alarm_q;

  logic tick_en, in_rng, load_ok, load_bad, adv;
  logic s_last, m_last, h_last, at_alarm;

  rtc_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk_i     (hclk),
    .rst_ni    (reset_n),
    .run_i     (state_q == ST_RUN),
    .clr_i     (load_ok),
    .tick_en_o (tick_en)
  );

  assign in_rng   = (set_sec <= SMAX) & (set_min <= MMAX) & (set_hr <= HMAX);
  assign load_ok  = set_valid & ready_q & in_rng;
  assign load_bad = set_valid & ready_q & ~in_rng;
  // A load in the same cycle as a tick wins; the tick is dropped.
  assign adv      = tick_en & ~load_ok;

  assign s_last   = (sec_q == SMAX);
  assign m_last   = (min_q == MMAX);
  assign h_last   = (hr_q == HMAX);
  assign at_alarm = (sec_d == alarm_sec) & (min_d == alarm_min) &
                    (hr_d == alarm_hr);

  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    hr_d  = hr_q;
    if (load_ok) begin
      sec_d = set_sec;
      min_d = set_min;
      hr_d  = set_hr;
    end else if (tick_en) begin
      sec_d = s_last ? '0 : sec_q + 1'b1;
      if (s_last) begin
        min_d = m_last ? '0 : min_q + 1'b1;
        if (m_last) hr_d = h_last ? '0 : hr_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STOP: begin
        if (load_ok)     state_d = ST_LOAD;
        else if (run_en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (load_ok)      state_d = ST_LOAD;
        else if (!run_en) state_d = ST_STOP;
      end
      ST_LOAD: state_d = run_en ? ST_RUN : ST_STOP;
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge hclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_STOP;
      sec_q   <= '0;
      min_q   <= '0;
      hr_q    <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      tick_q  <= 1'b0;
      mwrap_q <= 1'b0;
      dwrap_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      ready_q <= (state_d != ST_LOAD);
      err_q   <= load_bad;
      tick_q  <= adv;
      mwrap_q <= adv & s_last;
      dwrap_q <= adv & s_last & m_last & h_last;
      alarm_q <= adv & alarm_en & at_alarm;
    end
  end

  assign set_ready = ready_q;
  assign set_err   = err_q;
  assign seconds   = sec_q;
  assign minutes   = min_q;
  assign hours     = hr_q;
  assign tick      = tick_q;
  assign min_wrap  = mwrap_q;
  assign day_wrap  = dwrap_q;
  assign alarm_hit = alarm_q;

endmodule
